// File: rtl/ro_reg_bank_if.sv
// ro_reg_bank_if: status sampling and software read port of the read-only register bank.
// Master drives status words, snapshot strobe and read requests; slave returns
// read data, per-channel change flags and the level interrupt.
interface ro_reg_bank_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned ADDR_WIDTH = $clog2(NUM_CH)
);
    logic [NUM_CH*DATA_WIDTH-1:0] value_in;
    logic                         snap_req;
    logic                         rd_en;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic [DATA_WIDTH-1:0]        rd_data;
    logic                         rd_valid;
    logic [NUM_CH-1:0]            chg;
    logic                         irq;

    modport master (
        output value_in,
        output snap_req,
        output rd_en,
        output rd_addr,
        input  rd_data,
        input  rd_valid,
        input  chg,
        input  irq
    );

    modport slave (
        input  value_in,
        input  snap_req,
        input  rd_en,
        input  rd_addr,
        output rd_data,
        output rd_valid,
        output chg,
        output irq
    );
endinterface

// File: rtl/ro_reg_bank.sv
// ro_reg_bank: multi-channel read-only status register bank.
// Each channel is a live mirror or a sticky OR-accumulator (STICKY_MASK) with
// clear-on-read; per-channel change flags feed a level interrupt.
// Optional feature: define RO_REG_BANK_SNAPSHOT_EN to add an atomic snapshot
// array; reads then return the snapshot and snap_req becomes the clear event.
module ro_reg_bank #(
    parameter int unsigned       DATA_WIDTH  = 32,
    parameter int unsigned       NUM_CH      = 4,
    parameter int unsigned       ADDR_WIDTH  = $clog2(NUM_CH),
    parameter logic [NUM_CH-1:0] STICKY_MASK = '0
) (
    input  logic           clk,
    input  logic           rst,
    ro_reg_bank_if.slave   bus
);

    logic [DATA_WIDTH-1:0] vin_c     [NUM_CH];
    logic [DATA_WIDTH-1:0] v_q       [NUM_CH];
    logic [DATA_WIDTH-1:0] v_nxt_c   [NUM_CH];
    logic [NUM_CH-1:0]     chg_q;
    logic [NUM_CH-1:0]     chg_nxt_c;
    logic [NUM_CH-1:0]     clr_c;
    logic [DATA_WIDTH-1:0] rd_mux_c;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

`ifdef RO_REG_BANK_SNAPSHOT_EN
    logic [DATA_WIDTH-1:0] snap_q    [NUM_CH];
`else
    logic                  unused_snap_req;
    assign unused_snap_req = bus.snap_req;
`endif

    // Split the flat status bus into per-channel words
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            vin_c[i] = bus.value_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Clear event per channel: snapshot strobe, or a read addressing that channel
    always_comb begin
        clr_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef RO_REG_BANK_SNAPSHOT_EN
            clr_c[i] = bus.snap_req;
`else
            clr_c[i] = bus.rd_en && (bus.rd_addr == ADDR_WIDTH'(i));
`endif
        end
    end

    // Next value and change flag; a change in the clear cycle wins over the clear
    always_comb begin
        chg_nxt_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            v_nxt_c[i] = vin_c[i];
            if (STICKY_MASK[i] && !clr_c[i]) begin
                v_nxt_c[i] = v_q[i] | vin_c[i];
            end
            chg_nxt_c[i] = (v_nxt_c[i] != v_q[i]) || (chg_q[i] && !clr_c[i]);
        end
    end

    // Read mux; an address with no matching channel yields zero
    always_comb begin
        rd_mux_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_addr == ADDR_WIDTH'(i)) begin
`ifdef RO_REG_BANK_SNAPSHOT_EN
                rd_mux_c = snap_q[i];
`else
                rd_mux_c = v_q[i];
`endif
            end
        end
    end

    // Value registers and change flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                v_q[i] <= '0;
            end
            chg_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                v_q[i] <= v_nxt_c[i];
            end
            chg_q <= chg_nxt_c;
        end
    end

`ifdef RO_REG_BANK_SNAPSHOT_EN
    // Atomic capture of all value registers on the snapshot strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_q[i] <= '0;
            end
        end else if (bus.snap_req) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_q[i] <= v_q[i];
            end
        end
    end
`endif

    // Registered read port: data holds until the next read, valid is a pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= rd_mux_c;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.chg      = chg_q;
    assign bus.irq      = |chg_q;

endmodule
